// File: rtl/led_color_sequencer.sv
// LED color sequencer: an Avalon-MM register block that steps a 24-bit RGB
// output through a palette with a programmable dwell time. An optional
// per-channel fade moves the output one count per tick toward its target.
// When the sequencer is idle, the output shows a CPU-written manual color.
module led_color_sequencer #(
  parameter int DEPTH = 16,
  parameter int IDX_W = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic        read_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [23:0] out_port,
  output logic        irq
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [IDX_W:0] DEPTH_L = (IDX_W+1)'(DEPTH);

  logic              loop_q, fade_q, irq_en_q;
  logic [IDX_W:0]    len_q;
  logic [31:0]       dwell_q;
  logic [15:0]       prescale_q;
  logic [IDX_W-1:0]  pal_addr_q;
  logic [23:0]       manual_q;
  logic [23:0]       palette_q [DEPTH];
  logic [15:0]       pre_cnt_q, pre_cnt_d;
  state_t            state_q;
  logic [IDX_W-1:0]  idx_q;
  logic [31:0]       dwell_cnt_q;
  logic              done_q;
  logic [23:0]       out_q, out_d;

  logic              wr_en, wr_ctrl, wr_prescale, wr_pal_data, wr_status;
  logic              tick, dwell_hit, idx_oob;
  logic [IDX_W:0]    len_eff;
  logic [IDX_W-1:0]  last_idx;
  logic [31:0]       dwell_eff;
  logic [23:0]       target;
  logic              unused_rd;

  // Reads have no side effects, so the read strobe is not needed.
  assign unused_rd = read_n;

  assign wr_en       = chipselect & ~write_n;
  assign wr_ctrl     = wr_en && (address == 3'd0);
  assign wr_prescale = wr_en && (address == 3'd3);
  assign wr_pal_data = wr_en && (address == 3'd5);
  assign wr_status   = wr_en && (address == 3'd6);

  // Effective length and dwell: zero means one, length clamps to the palette depth.
  always_comb begin
    if (len_q == '0)          len_eff = {{IDX_W{1'b0}}, 1'b1};
    else if (len_q > DEPTH_L) len_eff = DEPTH_L;
    else                      len_eff = len_q;
    last_idx  = IDX_W'(len_eff - 1'b1);
    dwell_eff = (dwell_q == '0) ? 32'd1 : dwell_q;
  end

  assign tick      = (pre_cnt_q == prescale_q);
  assign dwell_hit = tick && ((dwell_cnt_q + 32'd1) >= dwell_eff);
  assign idx_oob   = ({1'b0, idx_q} >= len_eff);

  // Configuration registers; a PAL_DATA write post-increments the pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      loop_q     <= 1'b0;
      fade_q     <= 1'b0;
      irq_en_q   <= 1'b0;
      len_q      <= '0;
      dwell_q    <= '0;
      prescale_q <= '0;
      pal_addr_q <= '0;
      manual_q   <= '0;
    end else if (wr_en) begin
      case (address)
        3'd0: {irq_en_q, fade_q, loop_q} <= writedata[3:1];
        3'd1: len_q      <= writedata[IDX_W:0];
        3'd2: dwell_q    <= writedata;
        3'd3: prescale_q <= writedata[15:0];
        3'd4: pal_addr_q <= writedata[IDX_W-1:0];
        3'd5: pal_addr_q <= pal_addr_q + 1'b1;
        3'd7: manual_q   <= writedata[23:0];
        default: ;
      endcase
    end
  end

  // Palette storage, cleared on reset so reads after reset return zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) palette_q[i] <= '0;
    end else if (wr_pal_data) begin
      palette_q[pal_addr_q] <= writedata[23:0];
    end
  end

  assign pre_cnt_d = (wr_prescale || tick) ? 16'd0 : pre_cnt_q + 16'd1;

  // Free-running prescaler; rewriting PRESCALE restarts the count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pre_cnt_q <= '0;
    else       pre_cnt_q <= pre_cnt_d;
  end

  // Sequencer FSM: CTRL writes win over a same-cycle step advance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      dwell_cnt_q <= '0;
      done_q      <= 1'b0;
    end else if (wr_ctrl) begin
      done_q <= 1'b0;
      if (writedata[0]) begin
        state_q     <= S_RUN;
        idx_q       <= '0;
        dwell_cnt_q <= '0;
      end else begin
        state_q <= S_IDLE;
      end
    end else begin
      if (wr_status) done_q <= 1'b0;
      if (state_q == S_RUN) begin
        if (idx_oob) begin
          idx_q <= '0;
        end else if (tick) begin
          if (dwell_hit) begin
            dwell_cnt_q <= '0;
            if (idx_q == last_idx) begin
              if (loop_q) begin
                idx_q <= '0;
              end else begin
                state_q <= S_DONE;
                done_q  <= 1'b1;
              end
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end else begin
            dwell_cnt_q <= dwell_cnt_q + 32'd1;
          end
        end
      end
    end
  end

  // Color the output is heading for in the current state.
  always_comb begin
    case (state_q)
      S_RUN:   target = palette_q[idx_q];
      S_DONE:  target = palette_q[last_idx];
      default: target = manual_q;
    endcase
  end

  function automatic logic [7:0] toward(input logic [7:0] cur, input logic [7:0] tgt);
    if (cur < tgt)      return cur + 8'd1;
    else if (cur > tgt) return cur - 8'd1;
    else                return cur;
  endfunction

  // Next output: follow the target directly, or step each channel by one per tick.
  always_comb begin
    out_d = out_q;
    if (!fade_q)
      out_d = target;
    else if (tick)
      out_d = {toward(out_q[23:16], target[23:16]),
               toward(out_q[15:8],  target[15:8]),
               toward(out_q[7:0],   target[7:0])};
  end

  // Registered color output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) out_q <= '0;
    else       out_q <= out_d;
  end

  assign out_port = out_q;
  assign irq      = done_q & irq_en_q;

  // Zero-wait-state read mux; unused bits read as zero.
  always_comb begin
    readdata = '0;
    case (address)
      3'd0: readdata = {28'd0, irq_en_q, fade_q, loop_q, state_q == S_RUN};
      3'd1: readdata = 32'(len_q);
      3'd2: readdata = dwell_q;
      3'd3: readdata = {16'd0, prescale_q};
      3'd4: readdata = 32'(pal_addr_q);
      3'd5: readdata = {8'd0, palette_q[pal_addr_q]};
      3'd6: readdata = {16'd0, 8'(idx_q), 6'd0, done_q, state_q == S_RUN};
      3'd7: readdata = {8'd0, manual_q};
      default: readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_led_color_sequencer.sv
// Scoreboard bench for led_color_sequencer. Stimulus tasks push the expected
// color changes (value and clock edge) and read results into queues; two
// monitors pop and compare whenever out_port changes or a read is presented.
module tb_led_color_sequencer;
  localparam int DEPTH = 16;
  localparam int IDX_W = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  address = 3'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic        read_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic [23:0] out_port;
  logic        irq;

  led_color_sequencer #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .read_n(read_n), .writedata(writedata),
    .readdata(readdata), .out_port(out_port), .irq(irq)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [23:0] val; int at; } col_t;
  typedef struct { logic [2:0] a; logic [31:0] d; logic [31:0] m; logic ie; } rd_t;
  col_t colq[$];
  rd_t  rq[$];

  int          n_checks = 0;
  int          n_err = 0;
  bit          mon_en = 1'b0;
  logic [23:0] model_out = 24'd0;
  logic [23:0] prev_out = 24'd0;
  logic [23:0] manual_m = 24'd0;
  logic [23:0] pal_m [DEPTH];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] toward(input logic [7:0] c, input logic [7:0] t);
    if (c < t) return c + 8'd1;
    if (c > t) return c - 8'd1;
    return c;
  endfunction

  task automatic push_col(input logic [23:0] v, input int at);
    col_t e;
    if (v != model_out) begin
      e.val = v; e.at = at;
      colq.push_back(e);
      model_out = v;
    end
  endtask

  // Called at a negedge; returns the clock edge that samples the write.
  task automatic wr(input logic [2:0] a, input logic [31:0] d, output int e_o);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    e_o = cyc + 1;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] d, input logic [31:0] m, input logic ie);
    rd_t r;
    r.a = a; r.d = d; r.m = m; r.ie = ie;
    rq.push_back(r);
    address = a; chipselect = 1'b1; read_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; read_n = 1'b1;
  endtask

  task automatic wait_until(input int e);
    while (cyc < e) @(negedge clk);
  endtask

  // Color monitor: every change of out_port must match the next expected entry.
  always @(negedge clk) begin : mon_col
    col_t e;
    if (mon_en && (out_port !== prev_out)) begin
      if (colq.size() == 0) begin
        n_checks++; n_err++;
        $display("FAIL out_unexpected: got %h at edge %0d, expected no change", out_port, cyc);
      end else begin
        e = colq.pop_front();
        chk("out_value", {8'd0, out_port}, {8'd0, e.val});
        chk("out_edge", 32'(cyc), 32'(e.at));
      end
    end
    prev_out = out_port;
  end

  // Read monitor: samples readdata and irq shortly after the edge inside a read.
  initial begin : mon_rd
    rd_t r;
    forever begin
      @(posedge clk);
      #2;
      if (chipselect && !read_n) begin
        if (rq.size() == 0) begin
          n_checks++; n_err++;
          $display("FAIL read_unexpected: got %h, expected no read", readdata);
        end else begin
          r = rq.pop_front();
          chk($sformatf("read_addr%0d", r.a), readdata & r.m, r.d & r.m);
          chk("irq", {31'd0, irq}, {31'd0, r.ie});
        end
      end
    end
  end

  // Writes the model palette, starts a run and pushes the expected color trail.
  task automatic run_seq(input int len_w, input int dw_w, input int pres,
                         input bit loop_b, input bit irqen, input int loop_cycles);
    int e, p, c, len_eff, d_eff, k, cnt, t, stop, done_e;
    bit fin;
    logic [31:0] st;
    wr(3'd4, 32'd0, e);
    for (int i = 0; i < DEPTH; i++) wr(3'd5, {8'd0, pal_m[i]}, e);
    wr(3'd1, 32'(len_w), e);
    wr(3'd2, 32'(dw_w), e);
    wr(3'd3, 32'(pres), p);
    wr(3'd0, {28'd0, irqen, 1'b0, loop_b, 1'b1}, c);
    len_eff = (len_w == 0) ? 1 : (len_w > DEPTH) ? DEPTH : len_w;
    d_eff   = (dw_w == 0) ? 1 : dw_w;
    stop    = c + loop_cycles;
    push_col(pal_m[0], c + 1);
    k = 0; cnt = 0; fin = 1'b0; done_e = c;
    for (int m = 0; !fin; m++) begin
      t = p + (m + 1) * (pres + 1);
      if (t > c) begin
        if (loop_b && t >= stop) break;
        cnt++;
        if (cnt == d_eff) begin
          cnt = 0;
          if (k == len_eff - 1) begin
            if (loop_b) k = 0;
            else begin fin = 1'b1; done_e = t; end
          end else begin
            k++;
          end
          if (!fin) push_col(pal_m[k], t + 1);
        end
      end
    end
    if (loop_b) begin
      repeat (3) @(negedge clk);
      rd(3'd6, 32'h1, 32'hFF, 1'b0);
      wait_until(stop - 1);
      wr(3'd0, 32'd0, e);
      push_col(manual_m, e + 1);
    end else begin
      wait_until(done_e + 2);
      st = 32'((len_eff - 1) << 8);
      rd(3'd6, st | 32'h2, 32'hFFFF_FFFF, irqen);
      wr(3'd6, $urandom, e);
      rd(3'd6, st, 32'hFFFF_FFFF, 1'b0);
      wr(3'd0, 32'd0, e);
      push_col(manual_m, e + 1);
    end
    repeat (3) @(negedge clk);
  endtask

  // Fade toward tgt with fade already enabled; returns the edge of the last step.
  task automatic fade_to(input int pres, input logic [23:0] tgt, output int last);
    int p, w, t;
    logic [23:0] cur;
    wr(3'd3, 32'(pres), p);
    wr(3'd7, {8'd0, tgt}, w);
    manual_m = tgt;
    cur = model_out; last = w;
    for (int m = 0; cur != tgt; m++) begin
      t = p + (m + 1) * (pres + 1);
      if (t > w) begin
        cur = {toward(cur[23:16], tgt[23:16]), toward(cur[15:8], tgt[15:8]),
               toward(cur[7:0], tgt[7:0])};
        push_col(cur, t);
        last = t;
      end
    end
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int e, last, len_w, dw_w, pres;
    bit lp, ie;
    logic [23:0] a_col, b_col, col;

    repeat (3) @(negedge clk);
    reset = 1'b0;
    mon_en = 1'b1;
    chk("out_reset", {8'd0, out_port}, 32'd0);
    for (int i = 0; i < 8; i++) rd(3'(i), 32'd0, 32'hFFFF_FFFF, 1'b0);

    // Manual color, fade off: shows one cycle after the write.
    wr(3'd7, 32'h00A0B0C0, e);
    manual_m = 24'hA0B0C0;
    push_col(manual_m, e + 1);
    for (int i = 0; i < 3; i++) begin
      repeat (2) @(negedge clk);
      col = 24'($urandom);
      wr(3'd7, {8'd0, col}, e);
      manual_m = col;
      push_col(col, e + 1);
    end
    repeat (2) @(negedge clk);
    rd(3'd7, {8'd0, manual_m}, 32'hFFFF_FFFF, 1'b0);

    // Palette pointer wraps from the last entry back to entry 0.
    a_col = 24'($urandom); b_col = 24'($urandom);
    wr(3'd4, 32'(DEPTH - 1), e);
    wr(3'd5, {8'd0, a_col}, e);
    wr(3'd5, {8'd0, b_col}, e);
    rd(3'd4, 32'd1, 32'hFFFF_FFFF, 1'b0);
    wr(3'd4, 32'(DEPTH - 1), e);
    rd(3'd5, {8'd0, a_col}, 32'hFFFF_FFFF, 1'b0);
    wr(3'd4, 32'd0, e);
    rd(3'd5, {8'd0, b_col}, 32'hFFFF_FFFF, 1'b0);

    // Red, green, blue at dwell 4, then the same with looping.
    for (int i = 0; i < DEPTH; i++) pal_m[i] = 24'($urandom);
    pal_m[0] = 24'hFF0000; pal_m[1] = 24'h00FF00; pal_m[2] = 24'h0000FF;
    run_seq(3, 4, 0, 1'b0, 1'b0, 0);
    run_seq(3, 4, 0, 1'b1, 1'b1, 40);

    // LEN=0, DWELL=0 with irq enabled: one entry, done after one tick.
    run_seq(0, 0, 0, 1'b0, 1'b1, 0);

    // Randomized runs, including lengths beyond the palette depth.
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < DEPTH; i++) pal_m[i] = 24'($urandom);
      len_w = int'($urandom_range(0, 20));
      dw_w  = int'($urandom_range(0, 4));
      pres  = int'($urandom_range(0, 2));
      lp    = 1'($urandom);
      ie    = 1'($urandom);
      run_seq(len_w, dw_w, pres, lp, ie, int'($urandom_range(30, 150)));
    end

    // Fade: settle at black, then fade to 0x0302FF and two random colors.
    wr(3'd7, 32'd0, e);
    manual_m = 24'd0;
    push_col(24'd0, e + 1);
    repeat (2) @(negedge clk);
    wr(3'd0, 32'h4, e);
    fade_to(1, 24'h0302FF, last);
    wait_until(last + 2);
    for (int i = 0; i < 2; i++) begin
      fade_to(int'($urandom_range(0, 3)), 24'($urandom), last);
      wait_until(last + 2);
    end
    wr(3'd0, 32'd0, e);
    repeat (3) @(negedge clk);

    // Asynchronous reset in the middle of a run.
    for (int i = 0; i < DEPTH; i++) pal_m[i] = 24'($urandom);
    pal_m[0] = 24'h123456;
    run_seq(1, 1000, 0, 1'b1, 1'b1, 60);
    wr(3'd0, 32'h9, e);
    push_col(24'h123456, e + 1);
    repeat (4) @(negedge clk);
    mon_en = 1'b0;
    address = 3'd6;
    #2 reset = 1'b1;
    #1;
    chk("out_async_reset", {8'd0, out_port}, 32'd0);
    chk("status_async_reset", readdata, 32'd0);
    chk("irq_async_reset", {31'd0, irq}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    rd(3'd6, 32'd0, 32'hFFFF_FFFF, 1'b0);
    rd(3'd5, 32'd0, 32'hFFFF_FFFF, 1'b0);
    rd(3'd0, 32'd0, 32'hFFFF_FFFF, 1'b0);

    repeat (4) @(negedge clk);
    chk("color_queue_drained", 32'(colq.size()), 32'd0);
    chk("read_queue_drained", 32'(rq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
